// File: rtl/frame_scan_controller_pkg.sv
// Shared geometry, widths, FSM encoding and tag layout for the frame scan controller.
// The frame is 176x120 RGB332 pixels, read out as 20 horizontal bars of 6 rows each.
package frame_scan_controller_pkg;

  localparam int unsigned SCREEN_WIDTH     = 176;
  localparam int unsigned SCREEN_HEIGHT    = 120;
  localparam int unsigned BAR_HEIGHT       = 6;
  localparam int unsigned NUMBER_BARS      = SCREEN_HEIGHT / BAR_HEIGHT;
  localparam int unsigned PIXELS_PER_BAR   = SCREEN_WIDTH * BAR_HEIGHT;
  localparam int unsigned PIXELS_PER_FRAME = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam int unsigned ADDR_W           = 15;

  localparam int unsigned COL_W = $clog2(SCREEN_WIDTH);
  localparam int unsigned ROW_W = $clog2(BAR_HEIGHT);
  localparam int unsigned BAR_W = 5;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StFlush,
    StDone
  } scan_state_e;

  typedef struct packed {
    logic             valid;
    logic [BAR_W-1:0] bar;
    logic             bar_end;
    logic             frame_end;
  } scan_tag_t;

endpackage

// File: rtl/frame_scan_controller_tag_pipe.sv
// RD_LAT-deep shift register carrying pixel tags alongside the frame buffer read latency.
// A stage is written every cycle, so idle cycles shift in bubbles (valid=0).
module scan_tag_pipe
  import frame_scan_controller_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic      clk_i,
  input  logic      clear_i,
  input  scan_tag_t tag_i,
  output scan_tag_t tag_o,
  output logic      empty_next_o
);

  scan_tag_t stage_q [RD_LAT];

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      for (int i = 0; i < int'(RD_LAT); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_o = stage_q[RD_LAT-1];

  // True when the next edge leaves every stage empty, given no new issue this cycle.
  always_comb begin
    empty_next_o = 1'b1;
    for (int i = 0; i < int'(RD_LAT) - 1; i++) begin
      if (stage_q[i].valid) begin
        empty_next_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/frame_scan_controller.sv
// Scans the whole frame buffer once per START into the image processor, yielding the
// shared read port to the VGA driver and tagging each returned pixel with bar markers.
module frame_scan_controller
  import frame_scan_controller_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic              VGA_REQ,
  input  logic [ADDR_W-1:0] VGA_ADDR,
  output logic [ADDR_W-1:0] MEM_RD_ADDR,
  input  logic [7:0]        MEM_RD_DATA,
  output logic              PIX_VALID,
  output logic [7:0]        PIX_DATA,
  output logic [BAR_W-1:0]  PIX_BAR,
  output logic              PIX_BAR_END,
  output logic              PIX_FRAME_END,
  output logic              BUSY,
  output logic              DONE,
  output logic              OVERRUN
);

  scan_state_e       state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic [BAR_W-1:0]  bar_q;
  logic              overrun_q;

  logic      issue;
  logic      last_addr;
  logic      at_bar_end;
  logic      pipe_empty_next;
  scan_tag_t tag_in;
  scan_tag_t tag_out;

  assign issue      = (state_q == StScan) && !VGA_REQ;
  assign last_addr  = ptr_q == ADDR_W'(PIXELS_PER_FRAME - 1);
  assign at_bar_end = (col_q == COL_W'(SCREEN_WIDTH - 1)) && (row_q == ROW_W'(BAR_HEIGHT - 1));

  always_comb begin
    tag_in           = '0;
    tag_in.valid     = issue;
    tag_in.bar       = issue ? bar_q : '0;
    tag_in.bar_end   = issue && at_bar_end;
    tag_in.frame_end = issue && last_addr;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      col_q     <= '0;
      row_q     <= '0;
      bar_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= START && (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          if (START) begin
            state_q <= StScan;
            ptr_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            bar_q   <= '0;
          end
        end
        StScan: begin
          if (issue) begin
            if (last_addr) begin
              state_q <= StFlush;
              ptr_q   <= '0;
              col_q   <= '0;
              row_q   <= '0;
              bar_q   <= '0;
            end else begin
              ptr_q <= ptr_q + 1'b1;
              if (col_q == COL_W'(SCREEN_WIDTH - 1)) begin
                col_q <= '0;
                if (row_q == ROW_W'(BAR_HEIGHT - 1)) begin
                  row_q <= '0;
                  bar_q <= bar_q + 1'b1;
                end else begin
                  row_q <= row_q + 1'b1;
                end
              end else begin
                col_q <= col_q + 1'b1;
              end
            end
          end
        end
        StFlush: begin
          if (pipe_empty_next) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  scan_tag_pipe #(
    .RD_LAT(RD_LAT)
  ) u_tag_pipe (
    .clk_i       (CLK),
    .clear_i     (RESET),
    .tag_i       (tag_in),
    .tag_o       (tag_out),
    .empty_next_o(pipe_empty_next)
  );

  // VGA always wins the read port; the scan simply does not issue that cycle.
  assign MEM_RD_ADDR = VGA_REQ ? VGA_ADDR : ((state_q == StScan) ? ptr_q : '0);

  assign PIX_VALID     = tag_out.valid;
  assign PIX_DATA      = tag_out.valid ? MEM_RD_DATA : '0;
  assign PIX_BAR       = tag_out.bar;
  assign PIX_BAR_END   = tag_out.bar_end;
  assign PIX_FRAME_END = tag_out.frame_end;
  assign BUSY          = state_q != StIdle;
  assign DONE          = state_q == StDone;
  assign OVERRUN       = overrun_q;

endmodule

// File: tb/tb_frame_scan_controller.sv
// Self-checking bench: two controllers (RD_LAT=1 and RD_LAT=3) share stimulus, each
// reading its own latency-accurate model of a randomly filled frame buffer.
module tb_frame_scan_controller;

  localparam int NPIX = 21120;
  localparam int PPB  = 1056;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        START = 1'b0;
  logic        VGA_REQ = 1'b0;
  logic [14:0] VGA_ADDR = 15'h7FFF;

  logic [14:0] mem_rd_addr_1, mem_rd_addr_3;
  logic [7:0]  mem_rd_data_1, mem_rd_data_3;
  logic        pix_valid_1, pix_valid_3;
  logic [7:0]  pix_data_1, pix_data_3;
  logic [4:0]  pix_bar_1, pix_bar_3;
  logic        pix_bar_end_1, pix_bar_end_3;
  logic        pix_frame_end_1, pix_frame_end_3;
  logic        busy_1, busy_3, done_1, done_3, overrun_1, overrun_3;

  logic [7:0] mem [32768];
  logic [7:0] rd1_q;
  logic [7:0] rd3_q [3];

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    rd1_q    <= mem[mem_rd_addr_1];
    rd3_q[0] <= mem[mem_rd_addr_3];
    rd3_q[1] <= rd3_q[0];
    rd3_q[2] <= rd3_q[1];
  end
  assign mem_rd_data_1 = rd1_q;
  assign mem_rd_data_3 = rd3_q[2];

  frame_scan_controller #(.RD_LAT(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .START(START), .VGA_REQ(VGA_REQ), .VGA_ADDR(VGA_ADDR),
    .MEM_RD_ADDR(mem_rd_addr_1), .MEM_RD_DATA(mem_rd_data_1),
    .PIX_VALID(pix_valid_1), .PIX_DATA(pix_data_1), .PIX_BAR(pix_bar_1),
    .PIX_BAR_END(pix_bar_end_1), .PIX_FRAME_END(pix_frame_end_1),
    .BUSY(busy_1), .DONE(done_1), .OVERRUN(overrun_1)
  );

  frame_scan_controller #(.RD_LAT(3)) dut3 (
    .CLK(CLK), .RESET(RESET), .START(START), .VGA_REQ(VGA_REQ), .VGA_ADDR(VGA_ADDR),
    .MEM_RD_ADDR(mem_rd_addr_3), .MEM_RD_DATA(mem_rd_data_3),
    .PIX_VALID(pix_valid_3), .PIX_DATA(pix_data_3), .PIX_BAR(pix_bar_3),
    .PIX_BAR_END(pix_bar_end_3), .PIX_FRAME_END(pix_frame_end_3),
    .BUSY(busy_3), .DONE(done_3), .OVERRUN(overrun_3)
  );

  // Expected {data, bar, bar_end, frame_end} for pixel n of the frame.
  function automatic logic [14:0] exp_pix(input int n);
    logic [4:0] bar;
    bar = 5'(n / PPB);
    return {mem[n], bar, (n % PPB) == PPB - 1, n == NPIX - 1};
  endfunction

  // Advance one cycle and apply this cycle's inputs; outputs are sampled afterwards.
  task automatic drive(input logic rst, input logic st, input logic req);
    @(posedge CLK);
    #1;
    RESET   = rst;
    START   = st;
    VGA_REQ = req;
    #1;
  endtask

  task automatic test_reset;
    logic [3:0] obs;
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    obs = {pix_valid_1, busy_1, done_1, overrun_1};
    vectors++;
    if (obs !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_ctl1: got %b expected 0000", obs);
    end
    obs = {pix_valid_3, busy_3, done_3, overrun_3};
    vectors++;
    if (obs !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_ctl3: got %b expected 0000", obs);
    end
    vectors++;
    if ({pix_data_1, pix_bar_1, pix_bar_end_1, pix_frame_end_1} !== 15'h0) begin
      miscompares++;
      $display("FAIL reset_pix1: got %h/%h expected 00/00", pix_data_1, pix_bar_1);
    end
    vectors++;
    if (mem_rd_addr_1 !== 15'h0 || mem_rd_addr_3 !== 15'h0) begin
      miscompares++;
      $display("FAIL reset_addr: got %h/%h expected 0000/0000", mem_rd_addr_1, mem_rd_addr_3);
    end
  endtask

  task automatic test_reset_mid_scan;
    int cnt1 = 0;
    int cnt3 = 0;
    logic [7:0] obs;
    drive(1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 10000; c++) begin
      drive(c == 10000, 1'b0, 1'b0);
      cnt1 += int'(pix_valid_1);
      cnt3 += int'(pix_valid_3);
    end
    vectors++;
    if (cnt1 !== 9999 || cnt3 !== 9997) begin
      miscompares++;
      $display("FAIL pre_reset_count: got %0d/%0d expected 9999/9997", cnt1, cnt3);
    end
    for (int c = 10001; c <= 10010; c++) begin
      drive(1'b0, 1'b0, 1'b0);
      obs = {pix_valid_1, busy_1, done_1, overrun_1, pix_valid_3, busy_3, done_3, overrun_3};
      vectors++;
      if (obs !== 8'b0) begin
        miscompares++;
        $display("FAIL abort_ctl cycle %0d: got %b expected 00000000", c, obs);
      end
      vectors++;
      if (mem_rd_addr_1 !== 15'h0) begin
        miscompares++;
        $display("FAIL abort_addr cycle %0d: got %h expected 0000", c, mem_rd_addr_1);
      end
    end
  endtask

  // No stalls: every event lands on a fixed cycle counted from the START cycle.
  task automatic test_full_frame;
    logic [3:0]  obs, exp;
    logic [14:0] exp_addr;
    bit v1, v3;
    int bar_ends = 0;
    int frame_ends = 0;
    drive(1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= NPIX + 10; c++) begin
      drive(1'b0, 1'b0, 1'b0);
      exp_addr = (c <= NPIX) ? 15'(c - 1) : 15'h0;
      vectors++;
      if (mem_rd_addr_1 !== exp_addr || mem_rd_addr_3 !== exp_addr) begin
        miscompares++;
        $display("FAIL addr cycle %0d: got %h/%h expected %h", c, mem_rd_addr_1,
                 mem_rd_addr_3, exp_addr);
      end
      v1  = (c >= 2) && (c <= NPIX + 1);
      obs = {pix_valid_1, busy_1, done_1, overrun_1};
      exp = {v1, c <= NPIX + 2, c == NPIX + 2, 1'b0};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL ctl1 cycle %0d: got %b expected %b", c, obs, exp);
      end
      v3  = (c >= 4) && (c <= NPIX + 3);
      obs = {pix_valid_3, busy_3, done_3, overrun_3};
      exp = {v3, c <= NPIX + 4, c == NPIX + 4, 1'b0};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL ctl3 cycle %0d: got %b expected %b", c, obs, exp);
      end
      if (v1) begin
        vectors++;
        if ({pix_data_1, pix_bar_1, pix_bar_end_1, pix_frame_end_1} !== exp_pix(c - 2)) begin
          miscompares++;
          $display("FAIL pix1 n=%0d: got %h expected %h", c - 2,
                   {pix_data_1, pix_bar_1, pix_bar_end_1, pix_frame_end_1}, exp_pix(c - 2));
        end
      end
      if (v3) begin
        vectors++;
        if ({pix_data_3, pix_bar_3, pix_bar_end_3, pix_frame_end_3} !== exp_pix(c - 4)) begin
          miscompares++;
          $display("FAIL pix3 n=%0d: got %h expected %h", c - 4,
                   {pix_data_3, pix_bar_3, pix_bar_end_3, pix_frame_end_3}, exp_pix(c - 4));
        end
      end
      bar_ends   += int'(pix_valid_1 && pix_bar_end_1);
      frame_ends += int'(pix_valid_1 && pix_frame_end_1);
    end
    vectors++;
    if (bar_ends !== 20 || frame_ends !== 1) begin
      miscompares++;
      $display("FAIL marker_count: got %0d/%0d expected 20/1", bar_ends, frame_ends);
    end
  endtask

  // Random VGA stalls plus START at cycle 500 and in the DONE cycle, against an issue model.
  task automatic test_stall_overrun;
    int issued = 0;
    int done_c = -1;
    int pix_cnt = 0;
    int done_cnt = 0;
    bit pend_v = 0;
    int pend_n = 0;
    bit finished = 0;
    logic req, st;
    logic [14:0] exp_addr;
    logic [3:0]  obs, exp;
    drive(1'b0, 1'b1, 1'b0);
    for (int c = 1; c < 70000; c++) begin
      req = 1'($urandom_range(0, 1));
      st  = (c == 500) || (c == done_c);
      drive(1'b0, st, req);
      exp_addr = req ? 15'h7FFF : ((issued < NPIX) ? 15'(issued) : 15'h0);
      vectors++;
      if (mem_rd_addr_1 !== exp_addr) begin
        miscompares++;
        $display("FAIL stall_addr cycle %0d: got %h expected %h", c, mem_rd_addr_1, exp_addr);
      end
      obs = {pix_valid_1, busy_1, done_1, overrun_1};
      exp = {pend_v, (done_c < 0) || (c <= done_c), c == done_c,
             (c == 501) || (done_c >= 0 && c == done_c + 1)};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL stall_ctl cycle %0d: got %b expected %b", c, obs, exp);
      end
      if (pend_v) begin
        vectors++;
        if ({pix_data_1, pix_bar_1, pix_bar_end_1, pix_frame_end_1} !== exp_pix(pend_n)) begin
          miscompares++;
          $display("FAIL stall_pix n=%0d: got %h expected %h", pend_n,
                   {pix_data_1, pix_bar_1, pix_bar_end_1, pix_frame_end_1}, exp_pix(pend_n));
        end
      end
      pix_cnt  += int'(pix_valid_1);
      done_cnt += int'(done_1);
      pend_v = !req && (issued < NPIX);
      pend_n = issued;
      if (pend_v) begin
        if (issued == NPIX - 1) done_c = c + 2;
        issued++;
      end
      if (done_c >= 0 && c == done_c + 3) begin
        finished = 1;
        break;
      end
    end
    vectors++;
    if (!finished) begin
      miscompares++;
      $display("FAIL stall_timeout: got issued=%0d expected frame completion", issued);
    end
    vectors++;
    if (pix_cnt !== NPIX || done_cnt !== 1) begin
      miscompares++;
      $display("FAIL stall_counts: got %0d pixels %0d done expected %0d/1", pix_cnt, done_cnt,
               NPIX);
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
    test_reset();
    test_reset_mid_scan();
    test_full_frame();
    test_stall_overrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/frame_scan_controller.md
Name: frame_scan_controller

Overview:
Sequences one full read-out of the 176x120 RGB332 frame buffer into the colour/shape image processor after the camera has finished writing a frame. It shares the buffer's single read port with the VGA display driver, which always has priority. It also generates all addresses, tracks the memory read latency, and tags each returned pixel with its horizontal-bar index and end-of-bar/end-of-frame markers. It reports frame completion to the top level with a one-cycle pulse.

Parameters:
SCREEN_WIDTH, 176, pixels per row
SCREEN_HEIGHT, 120, rows per frame
BAR_HEIGHT, 6, rows per bar; SCREEN_HEIGHT must be a multiple of it (gives 20 bars)
ADDR_W, 15, frame buffer address width
RD_LAT, 1, frame buffer read latency in cycles (1..4)

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
START  in  1  one-cycle pulse: buffer holds a complete frame
VGA_REQ  in  1  VGA driver needs the read port this cycle
VGA_ADDR  in  ADDR_W  VGA read address
MEM_RD_ADDR  out  ADDR_W  frame buffer read address
MEM_RD_DATA  in  8  frame buffer read data, valid RD_LAT cycles after its address
PIX_VALID  out  1  PIX_* carries a scanned pixel
PIX_DATA  out  8  pixel value (RRRGGGBB)
PIX_BAR  out  5  bar index 0..19 of this pixel
PIX_BAR_END  out  1  last pixel of the current bar
PIX_FRAME_END  out  1  last pixel of the frame
BUSY  out  1  scan in progress
DONE  out  1  one-cycle pulse: frame fully delivered
OVERRUN  out  1  one-cycle pulse: START arrived while not IDLE

Behaviour:
- Reset (synchronous, active-high): state=IDLE, pointers and bar/row/column counters = 0, tag pipeline cleared. PIX_VALID, PIX_BAR_END, PIX_FRAME_END, BUSY, DONE and OVERRUN are 0 the cycle after RESET is sampled. PIX_DATA and PIX_BAR are 0.
- Reset mid-scan: in-flight tags are discarded. No PIX_VALID and no DONE are produced for the aborted frame.
- Port mux (combinational): MEM_RD_ADDR = VGA_ADDR when VGA_REQ=1. Otherwise MEM_RD_ADDR = the scan pointer; in IDLE and DONE it is held at 0.
- States:
  - IDLE: START=1 -> SCAN.
  - SCAN -> FLUSH after the last address (SCREEN_WIDTH*SCREEN_HEIGHT-1 = 21119) is issued.
  - FLUSH -> DONE when the tag pipeline is empty.
  - DONE lasts one cycle (DONE=1), then -> IDLE.
  - BUSY=1 in SCAN, FLUSH and DONE.
- Issue rule in SCAN: an address is issued in any cycle with VGA_REQ=0. On issue:
  - the pointer increments by 1 (no multiplier);
  - column wraps at SCREEN_WIDTH and increments row;
  - row-in-bar wraps at BAR_HEIGHT and increments bar.
  - With VGA_REQ=1 nothing is issued and all counters hold. Stall length is unbounded.
- Tag pipeline: RD_LAT-deep shift register of {valid, bar, bar_end, frame_end}. Each stage is written every cycle, with valid=0 when nothing is issued.
- At the pipeline output: PIX_VALID = tag valid and PIX_DATA = MEM_RD_DATA (combinational pass-through, zero added latency). PIX_BAR, PIX_BAR_END and PIX_FRAME_END come from the tag.
- PIX_BAR_END is 1 on pixel index k*1056-1. PIX_FRAME_END is 1 only on pixel 21119 (coincident with the bar-19 PIX_BAR_END).
- Ordering: exactly 21120 PIX_VALID pulses per frame, in ascending address order with no gaps or duplicates, regardless of the VGA_REQ pattern.
- START handling: START while not IDLE (including the DONE cycle) is ignored and pulses OVERRUN the next cycle. The scan continues unaffected.
- Latency with no stalls: START sampled in cycle 0 -> first address issued in cycle 1 -> first PIX_VALID in cycle 1+RD_LAT -> last PIX_VALID in cycle 21120+RD_LAT -> DONE in cycle 21121+RD_LAT.

Decomposition:
- Shared package: SCREEN_WIDTH, SCREEN_HEIGHT, BAR_HEIGHT, NUMBER_BARS (=20), PIXELS_PER_BAR (=1056), ADDR_W, and the state encoding (IDLE, SCAN, FLUSH, DONE).
- One natural sub-module, scan_tag_pipe: the parameterised RD_LAT-deep tag shift register with synchronous clear.

Test Plan:
- RESET, then START with VGA_REQ=0 and RD_LAT=1 -> MEM_RD_ADDR 0..21119 in cycles 1..21120; 21120 PIX_VALID with PIX_DATA equal to the RAM model contents; DONE pulse in cycle 21122; BUSY high in cycles 1..21122.
- Same run with VGA_REQ random at 50% and VGA_ADDR=0x7FFF -> MEM_RD_ADDR=0x7FFF whenever requested; pixel stream identical in order and content; DONE still exactly one pulse.
- Bar tagging -> PIX_BAR_END on pixels 1055, 2111, …, 21119; PIX_BAR=0 for pixel 1055 and 1 for pixel 1056; PIX_FRAME_END only on pixel 21119 with PIX_BAR=19.
- START pulsed at cycle 500 of a scan and again in the DONE cycle -> OVERRUN pulses in the following cycle each time; no restart; pixel count still 21120.
- RESET asserted at cycle 10000 -> next cycle PIX_VALID=0, BUSY=0, no DONE; a new START gives a full 21120-pixel frame beginning at address 0.
- RD_LAT=3 build, no stalls -> first PIX_VALID in cycle 4, DONE in cycle 21124, data aligned with the RAM model.
